// File: rtl/fir_stream_core.sv
// fir_stream_core: parametrised streaming FIR with loadable taps, warm-up gating and runtime decimation.
// Optional FIR_SAT_EN clamps the rounded result to the output range; otherwise it wraps.
module fir_stream_core #(
  parameter int DATA_W = 16,
  parameter int COEF_W = 20,
  parameter int FRAC   = 16,
  parameter int TAPS   = 32,
  parameter int OUT_W  = 16,
  parameter int DEC_W  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     data_valid,
  input  logic signed [DATA_W-1:0] data,
  input  logic                     flush,
  input  logic                     coef_wr,
  input  logic [5:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic [DEC_W-1:0]         dec_sel,
  output logic                     fir_valid,
  output logic signed [OUT_W-1:0]  fir_d,
  output logic                     warm
);
  localparam int PW = DATA_W + COEF_W;
  localparam int AW = PW + $clog2(TAPS);
  localparam int CW = $clog2(TAPS + 1);
  localparam int IW = $clog2(TAPS);
  logic signed [DATA_W-1:0] x [TAPS];
  logic signed [DATA_W-1:0] nx [TAPS];
  logic signed [COEF_W-1:0] c [TAPS];
  logic signed [PW-1:0] p [TAPS];
  logic signed [AW-1:0] acc, rnd;
  logic [CW-1:0] cnt;
  logic [DEC_W-1:0] ph, ph0, last_dec;
  logic p_v, accept, res, emit;
  logic [OUT_W-1:0] o;
`ifdef FIR_SAT_EN
  localparam logic signed [AW-1:0] OMAX = AW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [AW-1:0] OMIN = -OMAX - AW'(1);
  logic signed [AW-1:0] sh;
`endif
  assign warm = cnt == CW'(TAPS);
  always_comb begin
    nx[0] = data;
    for (int k = 1; k < TAPS; k++) nx[k] = x[k-1];
    acc = '0;
    for (int k = 0; k < TAPS; k++) acc = acc + AW'(p[k]);
    rnd = acc + (AW'(1) << (FRAC - 1));
`ifdef FIR_SAT_EN
    sh = rnd >>> FRAC;
    o = sh > OMAX ? {1'b0, {(OUT_W-1){1'b1}}} : sh < OMIN ? {1'b1, {(OUT_W-1){1'b0}}} : OUT_W'(sh);
`else
    o = OUT_W'(rnd >>> FRAC);
`endif
    accept = data_valid & ~flush;
    res = accept && cnt >= CW'(TAPS - 1);
    // a new decimation ratio restarts the phase so the next result is emitted
    ph0 = dec_sel != last_dec ? '0 : ph;
    emit = ph0 == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin
        x[k] <= '0;
        c[k] <= '0;
        p[k] <= '0;
      end
      cnt <= '0;
      ph <= '0;
      last_dec <= '0;
      p_v <= 1'b0;
      fir_valid <= 1'b0;
      fir_d <= '0;
    end else begin
      fir_valid <= p_v;
      if (p_v) fir_d <= o;
      p_v <= res && emit;
      if (accept) begin
        x <= nx;
        for (int k = 0; k < TAPS; k++) p[k] <= PW'(nx[k]) * PW'(c[k]);
        cnt <= warm ? cnt : cnt + 1'b1;
      end
      if (res) begin
        ph <= ph0 == dec_sel ? '0 : ph0 + 1'b1;
        last_dec <= dec_sel;
      end
      if (flush) begin
        for (int k = 0; k < TAPS; k++) x[k] <= '0;
        cnt <= '0;
        ph <= '0;
      end
      if (coef_wr && {1'b0, coef_addr} < 7'(TAPS)) c[coef_addr[IW-1:0]] <= coef_data;
    end
  end
endmodule

// File: tb/tb_fir_stream_core.sv
// tb_fir_stream_core: directed bench with a reference model feeding a timed scoreboard of expected outputs.
module tb_fir_stream_core;
  localparam int TAPS = 32;
  localparam int CWB = 24;
  typedef struct {int due; logic [15:0] v;} exp_t;
  logic clk = 0, rst = 1, data_valid = 0, flush = 0, coef_wr = 0;
  logic signed [15:0] data = 0;
  logic [5:0] coef_addr = 0;
  logic signed [CWB-1:0] coef_data = 0;
  logic [2:0] dec_sel = 0;
  logic fir_valid, warm;
  logic [15:0] fir_d;
  int errors = 0, checks = 0, cyc = 0, nv = 0, nv0;
  exp_t q[$];
  logic signed [15:0] mx [TAPS];
  logic signed [CWB-1:0] mc [TAPS];
  int mcnt, mph;
  logic [2:0] mlast;

  fir_stream_core #(.COEF_W(CWB), .TAPS(TAPS)) dut (
    .clk(clk), .rst(rst), .data_valid(data_valid), .data(data), .flush(flush),
    .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data), .dec_sel(dec_sel),
    .fir_valid(fir_valid), .fir_d(fir_d), .warm(warm));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] conv(input longint r);
`ifdef FIR_SAT_EN
    return r > 32767 ? 16'h7fff : r < -32768 ? 16'h8000 : 16'(r);
`else
    return 16'(r);
`endif
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (fir_valid) begin
      nv++;
      checks++;
      e = q.size() > 0 ? q.pop_front() : '{-1, 16'h0};
      assert (e.due == cyc && fir_d === e.v) else begin
        errors++;
        $error("FAIL out got=%h@%0d exp=%h@%0d", fir_d, cyc, e.v, e.due);
      end
    end else
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        checks++;
        assert (fir_valid) else begin
          errors++;
          $error("FAIL missing got=none@%0d exp=%h@%0d", cyc, e.v, e.due);
        end
      end
  end

  task automatic tick();
    longint s, r;
    if (rst) begin
      for (int k = 0; k < TAPS; k++) begin mx[k] = 0; mc[k] = 0; end
      mcnt = 0; mph = 0; mlast = 0;
    end else begin
      if (flush) begin
        for (int k = 0; k < TAPS; k++) mx[k] = 0;
        mcnt = 0; mph = 0;
      end else if (data_valid) begin
        for (int k = TAPS - 1; k > 0; k--) mx[k] = mx[k-1];
        mx[0] = data;
        if (mcnt < TAPS) mcnt++;
        if (mcnt == TAPS) begin
          s = 0;
          for (int k = 0; k < TAPS; k++) s += longint'(mx[k]) * longint'(mc[k]);
          r = (s + 64'sd32768) >>> 16;
          if (dec_sel != mlast) begin mph = 0; mlast = dec_sel; end
          if (mph == 0) q.push_back('{cyc + 2, conv(r)});
          mph = (mph == int'(dec_sel)) ? 0 : mph + 1;
        end
      end
      if (coef_wr && coef_addr < TAPS) mc[coef_addr] = coef_data;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic sample(input logic [15:0] d, input logic fl);
    data_valid = 1; data = d; flush = fl;
    tick();
    data_valid = 0; flush = 0;
  endtask

  task automatic wcoef(input int a, input logic [CWB-1:0] v);
    coef_wr = 1; coef_addr = 6'(a); coef_data = v;
    tick();
    coef_wr = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // reset with data_valid asserted
    data_valid = 1; data = 16'sh1234;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("rst_valid", 32'(fir_valid), 0);
      chk("rst_d", 32'(fir_d), 0);
      chk("rst_warm", 32'(warm), 0);
    end
    rst = 0; data_valid = 0;
    // impulse response
    for (int k = 0; k < TAPS; k++) wcoef(k, CWB'(k << 16));
    wcoef(40, CWB'(24'h7fffff));
    nv0 = nv;
    for (int i = 0; i < 31; i++) sample(0, 0);
    chk("warm_before", 32'(warm), 0);
    sample(1, 0);
    chk("warm_after", 32'(warm), 1);
    for (int i = 0; i < 31; i++) sample(0, 0);
    idle(2);
    chk("imp_count", 32'(nv - nv0), 32);
    chk("imp_last", 32'(fir_d), 31);
    // rounding half-up, coefficient 0.5 written alongside an old-coefficient sample
    for (int k = 1; k < TAPS; k++) wcoef(k, 0);
    data_valid = 1; data = 16'sd7; coef_wr = 1; coef_addr = 0; coef_data = CWB'(24'h008000);
    tick();
    data_valid = 0; coef_wr = 0;
    idle(1);
    chk("coef_old", 32'(fir_d), 0);
    sample(16'sd3, 0);
    idle(1);
    chk("round_pos", 32'(fir_d), 2);
    idle(3);
    chk("hold", 32'(fir_d), 2);
    sample(-16'sd3, 0);
    idle(1);
    chk("round_neg", 32'(fir_d), 32'h0000ffff);
    // overflow
    sample(0, 1);
    for (int k = 0; k < TAPS; k++) wcoef(k, CWB'(24'h010000));
    for (int i = 0; i < TAPS; i++) sample(16'h7fff, 0);
    idle(2);
`ifdef FIR_SAT_EN
    chk("ovf", 32'(fir_d), 32'h7fff);
`else
    chk("ovf", 32'(fir_d), 32'hffe0);
`endif
    // decimation by 4
    sample(0, 1);
    dec_sel = 3;
    for (int i = 0; i < 31; i++) sample(16'($urandom_range(0, 2000)) - 16'sd1000, 0);
    nv0 = nv;
    for (int i = 0; i < 40; i++) sample(16'($urandom_range(0, 2000)) - 16'sd1000, 0);
    idle(2);
    chk("dec_count", 32'(nv - nv0), 10);
    // flush on the middle of three back-to-back warm samples
    dec_sel = 0;
    nv0 = nv;
    sample(16'sd100, 0);
    sample(16'sd200, 1);
    chk("flush_warm", 32'(warm), 0);
    sample(16'sd300, 0);
    idle(3);
    chk("flush_count", 32'(nv - nv0), 1);
    for (int i = 0; i < 30; i++) sample(16'(i + 1), 0);
    idle(2);
    chk("rewarm_none", 32'(nv - nv0), 1);
    sample(16'sd5, 0);
    idle(2);
    chk("rewarm_one", 32'(nv - nv0), 2);
    idle(2);
    chk("sb_empty", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
